// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes, ALU codes.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    // Opcode class latched at DECODE so later changes on ins cannot perturb the sequence
    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_LD  = 3'd1,
        CLS_IMM = 3'd2,
        CLS_ST  = 3'd3,
        CLS_BR  = 3'd4,
        CLS_JAL = 3'd5,
        CLS_BAD = 3'd6
    } opclass_t;

    localparam logic [6:0] OPC_R   = 7'h33;
    localparam logic [6:0] OPC_LD  = 7'h03;
    localparam logic [6:0] OPC_IMM = 7'h13;
    localparam logic [6:0] OPC_ST  = 7'h23;
    localparam logic [6:0] OPC_BR  = 7'h63;
    localparam logic [6:0] OPC_JAL = 7'h6F;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: class, ALU source select, ALU op and load-result select.
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic       funct_b30,
    output opclass_t   cls,
    output logic       alu_src,
    output logic [2:0] op,
    output logic       mem2reg
);

    // Opcode lookup; anything not listed is reported as an illegal class
    always_comb begin
        cls     = CLS_BAD;
        alu_src = 1'b1;
        op      = ALU_ADD;
        mem2reg = 1'b0;
        case (opcode)
            OPC_R: begin
                cls     = CLS_R;
                alu_src = 1'b0;
                op      = funct_b30 ? ALU_SUB : ALU_ADD;
            end
            OPC_LD: begin
                cls     = CLS_LD;
                mem2reg = 1'b1;
            end
            OPC_IMM: begin
                cls = CLS_IMM;
            end
            OPC_ST: begin
                cls = CLS_ST;
                op  = ALU_SUB;
            end
            OPC_BR: begin
                cls     = CLS_BR;
                alu_src = 1'b0;
                op      = ALU_SUB;
            end
            OPC_JAL: begin
                cls = CLS_JAL;
            end
            default: begin
                cls = CLS_BAD;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control: FSM, PC register, cycle and retire counters.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0028,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ins,
    input  logic             zero,
    input  logic [31:0]      PCp4,
    input  logic [31:0]      imm,
    input  logic [31:0]      jTarget,
    input  logic             halt_req,
    output logic [31:0]      PC,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             Mem2Reg,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [2:0]       op,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] retired
);

    state_t   st;
    opclass_t cls_q;
    logic     halt_pend;
    logic     reg_write_q;
    logic     mem_write_q;

    opclass_t dec_cls;
    logic     dec_alu_src;
    logic [2:0] dec_op;
    logic     dec_mem2reg;

    // Only the opcode and the funct7 sub/add bit matter to control
    logic unused_ins;
    assign unused_ins = ^{ins[31], ins[29:7]};

    ctrl_decode u_decode (
        .opcode    (ins[6:0]),
        .funct_b30 (ins[30]),
        .cls       (dec_cls),
        .alu_src   (dec_alu_src),
        .op        (dec_op),
        .mem2reg   (dec_mem2reg)
    );

    assign state = st;

    // Write strobes are killed in the very cycle reset is seen, not one cycle later
    assign RegWrite = reg_write_q & ~reset;
    assign MemWrite = mem_write_q & ~reset;

    // FSM, PC, counters; outputs are registered against the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= S_FETCH;
            cls_q       <= CLS_R;
            halt_pend   <= 1'b0;
            PC          <= PC_RESET;
            cycles      <= '0;
            retired     <= '0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            MemRead     <= 1'b0;
            ALUSrc      <= 1'b0;
            Mem2Reg     <= 1'b0;
            op          <= 3'b000;
        end else begin
            cycles      <= cycles + CNT_W'(1);
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            MemRead     <= 1'b0;
            // Remember a halt request until the next instruction boundary
            if (halt_req) begin
                halt_pend <= 1'b1;
            end
            case (st)
                S_FETCH: begin
                    if (halt_req || halt_pend) begin
                        st        <= S_HALT;
                        halted    <= 1'b1;
                        halt_pend <= 1'b0;
                    end else begin
                        st <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec_cls == CLS_BAD) begin
                        st      <= S_HALT;
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                    end else begin
                        st      <= S_EXECUTE;
                        cls_q   <= dec_cls;
                        ALUSrc  <= dec_alu_src;
                        op      <= dec_op;
                        Mem2Reg <= dec_mem2reg;
                    end
                end
                S_EXECUTE: begin
                    case (cls_q)
                        CLS_LD: begin
                            st      <= S_MEMORY;
                            MemRead <= 1'b1;
                        end
                        CLS_ST: begin
                            st          <= S_MEMORY;
                            mem_write_q <= 1'b1;
                        end
                        CLS_BR: begin
                            // Branch resolves here, the only cycle zero is looked at
                            st      <= S_FETCH;
                            PC      <= zero ? (PC + (imm << 1)) : PCp4;
                            retired <= retired + CNT_W'(1);
                            ALUSrc  <= 1'b0;
                            op      <= 3'b000;
                            Mem2Reg <= 1'b0;
                        end
                        default: begin
                            st          <= S_WRITEBACK;
                            reg_write_q <= 1'b1;
                        end
                    endcase
                end
                S_MEMORY: begin
                    if (cls_q == CLS_LD) begin
                        st          <= S_WRITEBACK;
                        reg_write_q <= 1'b1;
                    end else begin
                        st      <= S_FETCH;
                        PC      <= PCp4;
                        retired <= retired + CNT_W'(1);
                        ALUSrc  <= 1'b0;
                        op      <= 3'b000;
                        Mem2Reg <= 1'b0;
                    end
                end
                S_WRITEBACK: begin
                    st      <= S_FETCH;
                    PC      <= (cls_q == CLS_JAL) ? (PC + (jTarget << 2)) : PCp4;
                    retired <= retired + CNT_W'(1);
                    ALUSrc  <= 1'b0;
                    op      <= 3'b000;
                    Mem2Reg <= 1'b0;
                end
                S_HALT: begin
                    st <= S_HALT;
                end
                default: begin
                    st <= S_FETCH;
                end
            endcase
        end
    end

endmodule
